// File: rtl/alarm_system_pkg.sv
// Shared defaults and state type for the intruder-alarm controller.
package alarm_system_pkg;

  localparam int CODE_W_DEF = 6;

  localparam logic [CODE_W_DEF-1:0] ARM_CODE_DEF    = 6'd4;
  localparam logic [CODE_W_DEF-1:0] DISARM_CODE_DEF = 6'd31;

  typedef enum logic [1:0] {
    DISARMED  = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2
  } alarm_state_e;

endpackage

// File: rtl/alarm_sync.sv
// Parameterised-width 2-flop synchroniser, asynchronous active-low reset.
module alarm_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops bring the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alarm_system.sv
// Intruder-alarm controller: keypad arm/disarm, latched alarm on any sensor while armed.
module alarm_system
  import alarm_system_pkg::*;
#(
  parameter int                 CODE_W      = CODE_W_DEF,
  parameter logic [CODE_W-1:0]  ARM_CODE    = ARM_CODE_DEF,
  parameter logic [CODE_W-1:0]  DISARM_CODE = DISARM_CODE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] Code,
  input  logic              Motion1,
  input  logic              Motion2,
  input  logic              Reed,
  output logic              act,
  output logic              alarm
);

  // Codes must differ and be nonzero, since the code pipeline resets to zero.
  if ((ARM_CODE == DISARM_CODE) || (ARM_CODE == '0) || (DISARM_CODE == '0)) begin : g_bad_codes
    $error("alarm_system: ARM_CODE and DISARM_CODE must differ and be nonzero");
  end

  logic [CODE_W-1:0] code_s;
  logic [CODE_W-1:0] code_q;
  logic [2:0]        sens_sync;
  logic              sens_s;
  logic              code_stable;
  logic              arm_hit;
  logic              disarm_hit;

  alarm_system_pkg::alarm_state_e state, state_nxt;

  alarm_sync #(.W(CODE_W)) u_code_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (Code),
    .q     (code_s)
  );

  alarm_sync #(.W(3)) u_sens_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({Motion1, Motion2, Reed}),
    .q     (sens_sync)
  );

  assign sens_s = |sens_sync;

  // One-cycle history of the synchronised code for the stability check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
    end else begin
      code_q <= code_s;
    end
  end

  // A code counts only after two identical synchronised samples (filters bus skew).
  always_comb begin
    code_stable = (code_s == code_q);
    arm_hit     = code_stable && (code_s == ARM_CODE);
    disarm_hit  = code_stable && (code_s == DISARM_CODE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DISARMED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; disarm takes priority over sensor activity.
  always_comb begin
    state_nxt = state;
    unique case (state)
      DISARMED: begin
        if (arm_hit) state_nxt = ARMED;
      end
      ARMED: begin
        if (disarm_hit)  state_nxt = DISARMED;
        else if (sens_s) state_nxt = TRIGGERED;
      end
      TRIGGERED: begin
        if (disarm_hit) state_nxt = DISARMED;
      end
      default: state_nxt = DISARMED;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    act   = 1'b0;
    alarm = 1'b0;
    unique case (state)
      DISARMED:  begin act = 1'b0; alarm = 1'b0; end
      ARMED:     begin act = 1'b1; alarm = 1'b0; end
      TRIGGERED: begin act = 1'b1; alarm = 1'b1; end
      default:   begin act = 1'b0; alarm = 1'b0; end
    endcase
  end

endmodule

// File: tb/tb_alarm_system.sv
// Self-checking bench for alarm_system: delay-line behavioural model plus directed checks.
module tb_alarm_system;

  logic       clk;
  logic       rst_n;
  logic [5:0] Code;
  logic       Motion1;
  logic       Motion2;
  logic       Reed;
  logic       act;
  logic       alarm;

  int total = 0;
  int bad   = 0;

  alarm_system #(
    .CODE_W      (6),
    .ARM_CODE    (6'd4),
    .DISARM_CODE (6'd31)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Code    (Code),
    .Motion1 (Motion1),
    .Motion2 (Motion2),
    .Reed    (Reed),
    .act     (act),
    .alarm   (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a code sampled at edges t-3 and t-2 that agrees is acted
  // on at edge t; a sensor sampled at edge t-2 is acted on at edge t.
  logic [5:0] ch1, ch2, ch3;
  logic       sh1, sh2;
  logic       m_act, m_alarm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch1 <= '0; ch2 <= '0; ch3 <= '0;
      sh1 <= 1'b0; sh2 <= 1'b0;
      m_act <= 1'b0; m_alarm <= 1'b0;
    end else begin
      ch1 <= Code; ch2 <= ch1; ch3 <= ch2;
      sh1 <= Motion1 | Motion2 | Reed; sh2 <= sh1;
      if (ch2 == ch3 && ch2 == 6'd31) begin
        m_act <= 1'b0; m_alarm <= 1'b0;
      end else if (!m_act) begin
        if (ch2 == ch3 && ch2 == 6'd4) m_act <= 1'b1;
      end else if (sh2) begin
        m_alarm <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    check("model_act", act, m_act);
    check("model_alarm", alarm, m_alarm);
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_sens(input logic m, input logic r);
    Motion1 = m; Motion2 = m; Reed = r;
  endtask

  task automatic arm_clean();
    set_sens(1'b0, 1'b0);
    Code = 6'd4;
    cycles(6);
  endtask

  initial begin
    logic [5:0] seq [6];
    logic [1:0] pairs [4];
    seq   = '{6'd6, 6'd1, 6'd31, 6'd15, 6'd4, 6'd15};
    pairs = '{2'b00, 2'b10, 2'b01, 2'b11};

    // Reset with arming code and sensors active must stay quiet.
    rst_n = 1'b0; Code = 6'd4; set_sens(1'b1, 1'b1);
    cycles(3);
    check("rst_act", act, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    Code = 6'd0; set_sens(1'b0, 1'b0);
    rst_n = 1'b1;
    cycles(6);
    check("post_rst_act", act, 1'b0);
    check("post_rst_alarm", alarm, 1'b0);

    // Code sequence: only ARM arms, exactly four edges after it is applied.
    for (int k = 0; k < 6; k++) begin
      Code = seq[k];
      if (seq[k] == 6'd4) begin
        cycles(3);
        check("arm_lat_before", act, 1'b0);
        cycles(1);
        check("arm_lat_at", act, 1'b1);
        cycles(1);
      end else begin
        cycles(5);
        check("seq_act", act, (k > 4) ? 1'b1 : 1'b0);
      end
    end

    // Sensor pairs while armed; disarm wins over live sensors.
    Code = 6'd31; cycles(5);
    for (int k = 0; k < 4; k++) begin
      arm_clean();
      check("pair_armed", act, 1'b1);
      set_sens(pairs[k][1], pairs[k][0]);
      if (pairs[k] == 2'b00) begin
        cycles(5);
        check("pair_idle_alarm", alarm, 1'b0);
      end else begin
        cycles(2);
        check("sens_lat_before", alarm, 1'b0);
        cycles(1);
        check("sens_lat_at", alarm, 1'b1);
      end
      Code = 6'd31; cycles(5);
      check("pair_disarm_act", act, 1'b0);
      check("pair_disarm_alarm", alarm, 1'b0);
    end

    // Latching: alarm survives the sensor clearing.
    arm_clean();
    Reed = 1'b1; cycles(4);
    Reed = 1'b0; cycles(5);
    check("latch_alarm", alarm, 1'b1);
    Code = 6'd31; cycles(5);
    check("latch_clear", alarm, 1'b0);

    // Disarmed: sensors ignored.
    set_sens(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      check("disarmed_act", act, 1'b0);
      check("disarmed_alarm", alarm, 1'b0);
    end
    set_sens(1'b0, 1'b0);

    // One-cycle glitch of ARM code is rejected.
    Code = 6'd0; cycles(3);
    Code = 6'd4; cycles(1);
    Code = 6'd0; cycles(6);
    check("glitch_act", act, 1'b0);

    // Arming with a sensor already active: ARMED then TRIGGERED next cycle.
    set_sens(1'b0, 1'b1);
    Code = 6'd4; cycles(4);
    check("arm_sens_act", act, 1'b1);
    check("arm_sens_alarm0", alarm, 1'b0);
    cycles(1);
    check("arm_sens_alarm1", alarm, 1'b1);

    // Disarm from TRIGGERED with sensors held high.
    Code = 6'd31; cycles(5);
    check("trig_disarm_act", act, 1'b0);
    check("trig_disarm_alarm", alarm, 1'b0);
    set_sens(1'b0, 1'b0);

    // Asynchronous reset mid-alarm, no clock edge needed.
    arm_clean();
    Motion1 = 1'b1; cycles(4);
    check("pre_areset_alarm", alarm, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_act", act, 1'b0);
    check("areset_alarm", alarm, 1'b0);
    Motion1 = 1'b0; Code = 6'd0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // Randomised phase against the model.
    for (int k = 0; k < 300; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)      Code = 6'd4;
      else if (sel < 8) Code = 6'd31;
      else              Code = 6'($urandom_range(0, 63));
      Motion1 = ($urandom_range(0, 9) == 0);
      Motion2 = ($urandom_range(0, 9) == 0);
      Reed    = ($urandom_range(0, 9) == 0);
      cycles($urandom_range(1, 6));
    end

    cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
